// File: rtl/ovi_store_sink_pkg.sv
// Shared types and constants for the OVI store sink.
// Provides bus widths, the store-window FSM state type, the sync configuration
// payload and the packet-count helpers used when a store window opens.
package ovi_store_sink_pkg;

    localparam int unsigned DATA_W  = 512;              // one OVI store beat
    localparam int unsigned CREDITS = 4;                // FIFO depth == credits owned by the vector unit
    localparam int unsigned DEPTH   = 16;               // scratch-memory entries
    localparam int unsigned VL_W    = 14;               // OVI vector-length field width
    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W   = VL_W;             // wide enough for ceil(VLmax*64/DATA_W)

    typedef enum logic [1:0] {
        SS_IDLE    = 2'd0,
        SS_COLLECT = 2'd1,
        SS_DONE    = 2'd2
    } store_state_t;

    // Fields sampled on SYNC_START
    typedef struct packed {
        logic [VL_W-1:0] vl;
        logic [1:0]      sew;
    } sync_cfg_t;

    // Element width in bits for a SEW code
    function automatic int unsigned sew_bits(input logic [1:0] sew);
        return 32'd8 << sew;
    endfunction

    // ceil(VL * element_bits / DATA_W), evaluated in 64 bits
    function automatic logic [CNT_W-1:0] calc_n_pkt(input sync_cfg_t cfg);
        logic [63:0] total_bits;
        total_bits = 64'(cfg.vl) * 64'(sew_bits(cfg.sew));
        return CNT_W'((total_bits + 64'(DATA_W - 1)) / 64'(DATA_W));
    endfunction

endpackage

// File: rtl/ovi_store_sink_if.sv
// Bus between the vector unit / memory model (master) and the store sink (slave).
//  sync_start, vl, sew      : store window request
//  store_valid, store_data  : store beats
//  store_credit             : one FIFO slot freed
//  wr_ready                 : scratch memory write backpressure
//  sync_end, busy, err      : window status
//  rd_addr, rd_data         : scratch memory readback
interface ovi_store_sink_if;
    import ovi_store_sink_pkg::*;

    logic              sync_start;
    logic [VL_W-1:0]   vl;
    logic [1:0]        sew;
    logic              store_valid;
    logic [DATA_W-1:0] store_data;
    logic              store_credit;
    logic              wr_ready;
    logic              sync_end;
    logic              busy;
    logic              err;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output sync_start, vl, sew, store_valid, store_data, wr_ready, rd_addr,
        input  store_credit, sync_end, busy, err, rd_data
    );

    modport slave (
        input  sync_start, vl, sew, store_valid, store_data, wr_ready, rd_addr,
        output store_credit, sync_end, busy, err, rd_data
    );

endinterface

// File: rtl/ovi_store_sink_credit_fifo.sv
// Credit-managed beat FIFO: one slot per credit held by the vector unit.
//  clk, rst_n   : clock, async active-low reset
//  push_i       : write wdata_i (ignored when full)
//  pop_i        : drop the head entry (ignored when empty)
//  wdata_i      : incoming beat
//  rdata_o      : current head entry (storage register, valid when !empty_o)
//  full_o       : occupancy == CREDITS
//  empty_o      : occupancy == 0
module ovi_store_sink_credit_fifo #(
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = (CREDITS > 1) ? $clog2(CREDITS) : 1;
    localparam int unsigned OCC_W = $clog2(CREDITS + 1);

    logic [DATA_W-1:0] slot_q [CREDITS];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              do_push_c, do_pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(CREDITS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full check uses the pre-pop occupancy
    assign do_push_c = push_i && !full_q;
    assign do_pop_c  = pop_i && !empty_q;

    // Pointer / occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + OCC_W'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_d = count_q - OCC_W'(1);
        end
        full_d  = (count_d == OCC_W'(CREDITS));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            slot_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = slot_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/ovi_store_sink.sv
// OVI store sink: accepts vector-store beats inside a memop sync window,
// buffers them in a credit FIFO, commits them to a DEPTH-entry scratch memory
// and pulses sync_end once the window's packet count has been committed.
//  clk, rst_n : clock, async active-low reset
//  bus_if     : slave side of ovi_store_sink_if (window request, beats,
//               credits, write backpressure, status, readback)
// SYNC_START is registered for one cycle (window parameters and the 64-bit
// packet count settle) before the FSM leaves IDLE; beats arriving in that
// cycle are dropped like any other beat outside a window.
module ovi_store_sink
    import ovi_store_sink_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    ovi_store_sink_if.slave bus_if
);

    store_state_t      state_q, state_d;
    logic              start_q;
    logic [CNT_W-1:0]  n_pkt_q;
    logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              busy_q, busy_d;
    logic              sync_end_q, sync_end_d;
    logic              err_q, err_d;

    sync_cfg_t         cfg_c;
    logic              start_acc_c;
    logic              push_c, pop_c, drop_c;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign cfg_c       = {bus_if.vl, bus_if.sew};
    // busy_q already covers the pending-start cycle, so a second start is refused
    assign start_acc_c = bus_if.sync_start && !busy_q;
    assign push_c      = bus_if.store_valid && (state_q == SS_COLLECT)
                         && !fifo_full && (rcv_cnt_q != n_pkt_q);
    assign drop_c      = bus_if.store_valid && !push_c;
    assign pop_c       = !fifo_empty && bus_if.wr_ready;

    ovi_store_sink_credit_fifo #(
        .DATA_W  (DATA_W),
        .CREDITS (CREDITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (bus_if.store_data),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Window FSM, counters and status next state
    always_comb begin
        state_d      = state_q;
        rcv_cnt_d    = rcv_cnt_q;
        commit_cnt_d = commit_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        err_d        = err_q;
        busy_d       = busy_q;
        sync_end_d   = 1'b0;

        if (push_c) begin
            rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
        end
        if (pop_c) begin
            commit_cnt_d = commit_cnt_q + CNT_W'(1);
            wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
        end

        unique case (state_q)
            SS_IDLE: begin
                if (start_q) begin
                    rcv_cnt_d    = '0;
                    commit_cnt_d = '0;
                    wr_ptr_d     = '0;
                    state_d      = (n_pkt_q == '0) ? SS_DONE : SS_COLLECT;
                end
            end
            SS_COLLECT: begin
                if (pop_c && (commit_cnt_q + CNT_W'(1) == n_pkt_q)) begin
                    state_d = SS_DONE;
                end
            end
            SS_DONE: begin
                state_d = SS_IDLE;
            end
            default: begin
                state_d = SS_IDLE;
            end
        endcase

        if (drop_c || (bus_if.sync_start && busy_q)) begin
            err_d = 1'b1;
        end
        busy_d     = start_acc_c || (state_d != SS_IDLE);
        sync_end_d = (state_d == SS_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SS_IDLE;
            start_q      <= 1'b0;
            n_pkt_q      <= '0;
            rcv_cnt_q    <= '0;
            commit_cnt_q <= '0;
            wr_ptr_q     <= '0;
            busy_q       <= 1'b0;
            sync_end_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_acc_c;
            if (start_acc_c) begin
                n_pkt_q <= calc_n_pkt(cfg_c);
            end
            rcv_cnt_q    <= rcv_cnt_d;
            commit_cnt_q <= commit_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            busy_q       <= busy_d;
            sync_end_q   <= sync_end_d;
            err_q        <= err_d;
        end
    end

    // Scratch memory: contents survive reset
    always_ff @(posedge clk) begin
        if (pop_c) begin
            mem_q[wr_ptr_q] <= fifo_head;
        end
    end

    // Credit returns in the commit cycle itself
    assign bus_if.store_credit = pop_c;
    assign bus_if.sync_end     = sync_end_q;
    assign bus_if.busy         = busy_q;
    assign bus_if.err          = err_q;
    assign bus_if.rd_data      = mem_q[bus_if.rd_addr];

endmodule

// File: tb/tb_ovi_store_sink.sv
// Self-checking bench for ovi_store_sink with a queue/array reference model.
module tb_ovi_store_sink;
    import ovi_store_sink_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ovi_store_sink_if bus_if ();

    ovi_store_sink dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    int credit_cnt = 0;
    int sync_end_cnt = 0;
    int last_credit_cyc = -1;
    int last_sync_end_cyc = -1;

    // Reference model: scratch memory image and the beats sent in the current window
    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                model_vld [DEPTH];
    logic [DATA_W-1:0] sent_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_if.store_credit === 1'b1) begin
            credit_cnt++;
            last_credit_cyc = cyc;
        end
        if (rst_n === 1'b1 && bus_if.sync_end === 1'b1) begin
            sync_end_cnt++;
            last_sync_end_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.sync_start  = 1'b0;
        bus_if.vl          = '0;
        bus_if.sew         = '0;
        bus_if.store_valid = 1'b0;
        bus_if.store_data  = '0;
        bus_if.rd_addr     = '0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle_inputs();
        bus_if.wr_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [DATA_W-1:0] rand_beat();
        logic [DATA_W-1:0] b;
        for (int i = 0; i < int'(DATA_W / 32); i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic int exp_n_pkt(input int vl, input int sew);
        return (vl * (8 << sew) + int'(DATA_W) - 1) / int'(DATA_W);
    endfunction

    // Window beats land at consecutive addresses from 0, modulo DEPTH
    task automatic model_commit(input int count);
        for (int i = 0; i < count; i++) begin
            model_mem[i % DEPTH] = sent_q[i];
            model_vld[i % DEPTH] = 1'b1;
        end
    endtask

    // Pulse sync_start in cycle s and return at the first cycle beats can be taken (s+2)
    task automatic start_window(input int vl, input int sew, output int s);
        bus_if.sync_start = 1'b1;
        bus_if.vl         = VL_W'(vl);
        bus_if.sew        = 2'(sew);
        s = cyc;
        tick();
        bus_if.sync_start = 1'b0;
        tick();
    endtask

    // Vector-unit model: spends credits, random write backpressure, stops on sync_end
    task automatic drive_window(input int n, input int ready_pct, output bit done);
        int sent;
        int base_credit;
        int base_end;
        sent        = 0;
        base_credit = credit_cnt;
        base_end    = sync_end_cnt;
        done        = 1'b0;
        sent_q.delete();
        for (int budget = 0; budget < 2000; budget++) begin
            bus_if.wr_ready = ($urandom_range(99) < ready_pct);
            if (sent < n && (sent - (credit_cnt - base_credit)) < int'(CREDITS)) begin
                bus_if.store_valid = 1'b1;
                bus_if.store_data  = rand_beat();
                sent_q.push_back(bus_if.store_data);
                sent++;
            end else begin
                bus_if.store_valid = 1'b0;
            end
            tick();
            if (sync_end_cnt != base_end) begin
                done = 1'b1;
                break;
            end
        end
        bus_if.store_valid = 1'b0;
        bus_if.wr_ready    = 1'b0;
    endtask

    task automatic wait_sync_end(input int base, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sync_end_cnt != base) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus_if.wr_ready = 1'b1;
        repeat (2) tick();
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", bus_if.busy); end
        vectors++; if (bus_if.sync_end !== 1'b0) begin miscompares++; $display("FAIL reset_sync_end got %b exp 0", bus_if.sync_end); end
        vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", bus_if.err); end
        vectors++; if (bus_if.store_credit !== 1'b0) begin miscompares++; $display("FAIL reset_credit got %b exp 0", bus_if.store_credit); end
        rst_n = 1'b1;
        tick();
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b exp 0", bus_if.busy); end
    endtask

    task automatic test_single_beat();
        int s, t, base_c, base_e;
        bit seen;
        logic [DATA_W-1:0] beat;
        reset_dut();
        bus_if.wr_ready = 1'b1;
        base_c = credit_cnt;
        base_e = sync_end_cnt;
        start_window(8, 2, s);
        beat = rand_beat();
        bus_if.store_valid = 1'b1;
        bus_if.store_data  = beat;
        t = cyc;
        tick();
        bus_if.store_valid = 1'b0;
        wait_sync_end(base_e, 20, seen);
        repeat (2) tick();
        vectors++; if (!seen) begin miscompares++; $display("FAIL single_sync_end_timeout got none exp pulse"); end
        vectors++; if (credit_cnt - base_c != 1) begin miscompares++; $display("FAIL single_credits got %0d exp 1", credit_cnt - base_c); end
        vectors++; if (last_credit_cyc != t + 1) begin miscompares++; $display("FAIL single_credit_cycle got %0d exp %0d", last_credit_cyc, t + 1); end
        vectors++; if (last_sync_end_cyc != t + 2) begin miscompares++; $display("FAIL single_sync_end_cycle got %0d exp %0d", last_sync_end_cyc, t + 2); end
        vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL single_err got %b exp 0", bus_if.err); end
        model_mem[0] = beat;
        model_vld[0] = 1'b1;
        bus_if.rd_addr = '0;
        #1;
        vectors++; if (bus_if.rd_data !== model_mem[0]) begin miscompares++; $display("FAIL single_mem0 got %h exp %h", bus_if.rd_data, model_mem[0]); end
    endtask

    task automatic test_backpressure();
        int s, base_c, base_e;
        reset_dut();
        bus_if.wr_ready = 1'b0;
        base_c = credit_cnt;
        base_e = sync_end_cnt;
        start_window(64, 3, s);
        sent_q.delete();
        for (int i = 0; i < 7; i++) begin
            bus_if.store_valid = 1'b1;
            bus_if.store_data  = rand_beat();
            sent_q.push_back(bus_if.store_data);
            tick();
        end
        bus_if.store_valid = 1'b0;
        repeat (3) tick();
        vectors++; if (bus_if.err !== 1'b1) begin miscompares++; $display("FAIL bp_err got %b exp 1", bus_if.err); end
        vectors++; if (credit_cnt != base_c) begin miscompares++; $display("FAIL bp_credits_stalled got %0d exp 0", credit_cnt - base_c); end
        bus_if.wr_ready = 1'b1;
        repeat (12) tick();
        bus_if.wr_ready = 1'b0;
        vectors++; if (credit_cnt - base_c != int'(CREDITS)) begin miscompares++; $display("FAIL bp_credits got %0d exp %0d", credit_cnt - base_c, CREDITS); end
        vectors++; if (sync_end_cnt != base_e) begin miscompares++; $display("FAIL bp_no_sync_end got %0d exp 0", sync_end_cnt - base_e); end
        vectors++; if (bus_if.busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy got %b exp 1", bus_if.busy); end
        model_commit(int'(CREDITS));
        for (int a = 0; a < int'(DEPTH); a++) if (model_vld[a]) begin
            bus_if.rd_addr = ADDR_W'(a);
            #1;
            vectors++;
            if (bus_if.rd_data !== model_mem[a]) begin miscompares++; $display("FAIL bp_mem[%0d] got %h exp %h", a, bus_if.rd_data, model_mem[a]); end
        end
    endtask

    task automatic test_zero_vl();
        int s, base_c, base_e;
        bit seen;
        reset_dut();
        bus_if.wr_ready = 1'b1;
        base_c = credit_cnt;
        base_e = sync_end_cnt;
        bus_if.sync_start = 1'b1;
        bus_if.vl  = '0;
        bus_if.sew = 2'(3);
        s = cyc;
        tick();
        bus_if.sync_start = 1'b0;
        vectors++; if (bus_if.busy !== 1'b1) begin miscompares++; $display("FAIL zero_busy got %b exp 1", bus_if.busy); end
        wait_sync_end(base_e, 10, seen);
        repeat (3) tick();
        vectors++; if (last_sync_end_cyc != s + 2 || !seen) begin miscompares++; $display("FAIL zero_sync_end_cycle got %0d exp %0d", last_sync_end_cyc, s + 2); end
        vectors++; if (sync_end_cnt - base_e != 1) begin miscompares++; $display("FAIL zero_sync_end_count got %0d exp 1", sync_end_cnt - base_e); end
        vectors++; if (credit_cnt != base_c) begin miscompares++; $display("FAIL zero_credits got %0d exp 0", credit_cnt - base_c); end
        vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL zero_err got %b exp 0", bus_if.err); end
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy_after got %b exp 0", bus_if.busy); end
    endtask

    task automatic test_random_windows();
        int s, n, vl, sew, base_c, base_e;
        bit done;
        reset_dut();
        for (int w = 0; w < 6; w++) begin
            if (w == 0) begin
                vl = 128; sew = 3;     // exactly DEPTH packets
            end else begin
                vl  = $urandom_range(1, 300);
                sew = $urandom_range(0, 3);
            end
            n = exp_n_pkt(vl, sew);
            base_c = credit_cnt;
            base_e = sync_end_cnt;
            start_window(vl, sew, s);
            drive_window(n, 60, done);
            repeat (3) tick();
            vectors++; if (!done) begin miscompares++; $display("FAIL win%0d_timeout got no sync_end exp pulse (n=%0d)", w, n); end
            vectors++; if (credit_cnt - base_c != n) begin miscompares++; $display("FAIL win%0d_credits got %0d exp %0d", w, credit_cnt - base_c, n); end
            vectors++; if (sync_end_cnt - base_e != 1) begin miscompares++; $display("FAIL win%0d_sync_end_count got %0d exp 1", w, sync_end_cnt - base_e); end
            vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL win%0d_err got %b exp 0", w, bus_if.err); end
            model_commit(n);
            for (int a = 0; a < int'(DEPTH); a++) if (model_vld[a]) begin
                bus_if.rd_addr = ADDR_W'(a);
                #1;
                vectors++;
                if (bus_if.rd_data !== model_mem[a]) begin miscompares++; $display("FAIL win%0d_mem[%0d] got %h exp %h", w, a, bus_if.rd_data, model_mem[a]); end
            end
        end
    endtask

    task automatic test_drops();
        int s, base_c, base_e;
        bit seen, done;
        // Extra beat beyond n_pkt
        reset_dut();
        bus_if.wr_ready = 1'b0;
        base_c = credit_cnt;
        base_e = sync_end_cnt;
        start_window(16, 3, s);
        sent_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus_if.store_valid = 1'b1;
            bus_if.store_data  = rand_beat();
            sent_q.push_back(bus_if.store_data);
            tick();
        end
        bus_if.store_valid = 1'b0;
        tick();
        vectors++; if (bus_if.err !== 1'b1) begin miscompares++; $display("FAIL extra_beat_err got %b exp 1", bus_if.err); end
        bus_if.wr_ready = 1'b1;
        wait_sync_end(base_e, 20, seen);
        repeat (2) tick();
        vectors++; if (!seen) begin miscompares++; $display("FAIL extra_beat_sync_end got none exp pulse"); end
        vectors++; if (credit_cnt - base_c != 2) begin miscompares++; $display("FAIL extra_beat_credits got %0d exp 2", credit_cnt - base_c); end
        model_commit(2);
        for (int a = 0; a < int'(DEPTH); a++) if (model_vld[a]) begin
            bus_if.rd_addr = ADDR_W'(a);
            #1;
            vectors++;
            if (bus_if.rd_data !== model_mem[a]) begin miscompares++; $display("FAIL extra_beat_mem[%0d] got %h exp %h", a, bus_if.rd_data, model_mem[a]); end
        end
        // Beat while idle
        reset_dut();
        vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL idle_err_cleared got %b exp 0", bus_if.err); end
        base_c = credit_cnt;
        bus_if.wr_ready    = 1'b1;
        bus_if.store_valid = 1'b1;
        bus_if.store_data  = rand_beat();
        tick();
        bus_if.store_valid = 1'b0;
        repeat (3) tick();
        vectors++; if (bus_if.err !== 1'b1) begin miscompares++; $display("FAIL idle_beat_err got %b exp 1", bus_if.err); end
        vectors++; if (credit_cnt != base_c) begin miscompares++; $display("FAIL idle_beat_credits got %0d exp 0", credit_cnt - base_c); end
        for (int a = 0; a < int'(DEPTH); a++) if (model_vld[a]) begin
            bus_if.rd_addr = ADDR_W'(a);
            #1;
            vectors++;
            if (bus_if.rd_data !== model_mem[a]) begin miscompares++; $display("FAIL idle_beat_mem[%0d] got %h exp %h", a, bus_if.rd_data, model_mem[a]); end
        end
        // SYNC_START while busy is ignored but flagged
        reset_dut();
        base_e = sync_end_cnt;
        bus_if.sync_start = 1'b1;
        bus_if.vl  = VL_W'(8);
        bus_if.sew = 2'(2);
        tick();
        bus_if.vl = '0;
        tick();
        bus_if.sync_start = 1'b0;
        vectors++; if (bus_if.err !== 1'b1) begin miscompares++; $display("FAIL restart_err got %b exp 1", bus_if.err); end
        drive_window(1, 100, done);
        repeat (2) tick();
        vectors++; if (!done || sync_end_cnt - base_e != 1) begin miscompares++; $display("FAIL restart_sync_end got %0d exp 1", sync_end_cnt - base_e); end
        model_commit(1);
    endtask

    task automatic test_reset_mid();
        int s, base_c, base_e;
        bit done;
        reset_dut();
        bus_if.wr_ready = 1'b1;
        base_c = credit_cnt;
        base_e = sync_end_cnt;
        start_window(64, 3, s);
        sent_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus_if.store_valid = 1'b1;
            bus_if.store_data  = rand_beat();
            sent_q.push_back(bus_if.store_data);
            tick();
        end
        bus_if.store_valid = 1'b0;
        repeat (3) tick();
        vectors++; if (credit_cnt - base_c != 3) begin miscompares++; $display("FAIL mid_credits got %0d exp 3", credit_cnt - base_c); end
        vectors++; if (bus_if.busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got %b exp 1", bus_if.busy); end
        model_commit(3);
        rst_n = 1'b0;
        #1;
        vectors++; if (bus_if.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b exp 0", bus_if.busy); end
        vectors++; if (bus_if.sync_end !== 1'b0) begin miscompares++; $display("FAIL abort_sync_end got %b exp 0", bus_if.sync_end); end
        vectors++; if (bus_if.store_credit !== 1'b0) begin miscompares++; $display("FAIL abort_credit got %b exp 0", bus_if.store_credit); end
        vectors++; if (bus_if.err !== 1'b0) begin miscompares++; $display("FAIL abort_err got %b exp 0", bus_if.err); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (sync_end_cnt != base_e) begin miscompares++; $display("FAIL abort_no_sync_end got %0d exp 0", sync_end_cnt - base_e); end
        base_c = credit_cnt;
        start_window(16, 3, s);
        drive_window(2, 100, done);
        repeat (2) tick();
        vectors++; if (!done) begin miscompares++; $display("FAIL after_abort_timeout got no sync_end exp pulse"); end
        vectors++; if (credit_cnt - base_c != 2) begin miscompares++; $display("FAIL after_abort_credits got %0d exp 2", credit_cnt - base_c); end
        model_commit(2);
        for (int a = 0; a < int'(DEPTH); a++) if (model_vld[a]) begin
            bus_if.rd_addr = ADDR_W'(a);
            #1;
            vectors++;
            if (bus_if.rd_data !== model_mem[a]) begin miscompares++; $display("FAIL after_abort_mem[%0d] got %h exp %h", a, bus_if.rd_data, model_mem[a]); end
        end
    endtask

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) model_vld[a] = 1'b0;
        test_reset();
        test_single_beat();
        test_backpressure();
        test_zero_vl();
        test_random_windows();
        test_drops();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
